// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock,
// into a buffer that is read back in forward (encrypt) or reverse (decrypt) order.
module t_change (
  input  logic [31:0] i_a,
  output logic [31:0] o_b
);
  // Standard SM4 S-box, element 0 first.
  localparam logic [0:255][7:0] SBOX = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  assign o_b = {SBOX[i_a[31:24]], SBOX[i_a[23:16]], SBOX[i_a[15:8]], SBOX[i_a[7:0]]};
endmodule

module sm4_key_expand (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_valid,
  output logic         done,
  input  logic [4:0]   rk_addr,
  input  logic         decrypt,
  output logic [0:31]  rk_out
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_k0, r_k1, r_k2, r_k3;
  logic [4:0]  r_cnt;
  logic [31:0] r_mem [32];
  logic        r_keys_valid, r_done;
  logic [31:0] r_rk_out;

  logic        w_load;
  logic [7:0]  w_ck_base;
  logic [31:0] w_ck, w_t_in, w_tau, w_lp, w_rk;
  logic [4:0]  w_rd_idx;

  // CK_i bytes are 7*(4i+j) mod 256, so the row base is 28*i and bytes step by 7.
  assign w_ck_base = {3'b000, r_cnt} * 8'd28;
  assign w_ck      = {w_ck_base, w_ck_base + 8'd7, w_ck_base + 8'd14, w_ck_base + 8'd21};
  assign w_t_in    = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;

  t_change u_t_change (
    .i_a (w_t_in),
    .o_b (w_tau)
  );

  assign w_lp     = w_tau ^ {w_tau[18:0], w_tau[31:19]} ^ {w_tau[8:0], w_tau[31:9]};
  assign w_rk     = r_k0 ^ w_lp;
  assign w_load   = key_valid && key_ready;
  assign w_rd_idx = decrypt ? (5'd31 - rk_addr) : rk_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k0         <= '0;
      r_k1         <= '0;
      r_k2         <= '0;
      r_k3         <= '0;
      r_cnt        <= '0;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
      r_rk_out     <= '0;
      // NOTE: the key buffer is flop-based and cleared on reset so an aborted
      // schedule can never leak stale round keys.
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout, so the read below sees the pre-write word.
      r_done   <= 1'b0;
      r_rk_out <= r_mem[w_rd_idx];
      if (w_load) begin
        r_k0         <= key_in[0:31]   ^ FK0;
        r_k1         <= key_in[32:63]  ^ FK1;
        r_k2         <= key_in[64:95]  ^ FK2;
        r_k3         <= key_in[96:127] ^ FK3;
        r_cnt        <= '0;
        r_keys_valid <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_mem[r_cnt] <= w_rk;
        r_k0         <= r_k1;
        r_k1         <= r_k2;
        r_k2         <= r_k3;
        r_k3         <= w_rk;
        r_cnt        <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_done       <= 1'b1;
          r_keys_valid <= 1'b1;
        end
      end
    end
  end

  assign keys_valid = r_keys_valid;
  assign done       = r_done;
  assign rk_out     = r_rk_out;
endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed and randomised checks of the SM4 key-schedule engine against
// published round keys and an independent software key schedule.
module tb_sm4_key_expand;
  logic         clk;
  logic         reset_n;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic         done;
  logic [4:0]   rk_addr;
  logic         decrypt;
  logic [0:31]  rk_out;

  int n_run;
  int n_fail;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] ALT_KEY = 128'hDEADBEEF0011223344556677CAFEF00D;

  localparam logic [0:255][7:0] SBOX = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  logic [31:0] ref_rk  [32];
  logic [31:0] prev_rk [32];

  sm4_key_expand dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .done       (done),
    .rk_addr    (rk_addr),
    .decrypt    (decrypt),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference key schedule written from the textbook algorithm.
  function automatic logic [31:0] t_prime(input logic [31:0] a);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[31-8*j -: 8] = SBOX[a[31-8*j -: 8]];
    return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
  endfunction

  task automatic model_ks(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] ck, rk;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      rk = k[0] ^ t_prime(k[1] ^ k[2] ^ k[3] ^ ck);
      ref_rk[i] = rk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Caller is always #1 after a rising edge; the key is sampled at the next edge.
  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic read_word(input logic [4:0] addr, input logic dec, output logic [31:0] d);
    rk_addr = addr;
    decrypt = dec;
    @(posedge clk); #1;
    d = rk_out;
  endtask

  // Waits for done after a load; returns the edge count, or 0 on timeout.
  task automatic wait_done(output int cyc, output int ready_hi);
    cyc = 0;
    ready_hi = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      if (key_ready !== 1'b0) ready_hi++;
    end
  endtask

  task automatic test_reset();
    n_run++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset key_ready: got %b want 1", key_ready); end
    n_run++;
    if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset keys_valid: got %b want 0", keys_valid); end
    n_run++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_run++;
    if (rk_out !== 32'h0) begin n_fail++; $display("FAIL reset rk_out: got %h want 00000000", rk_out); end
  endtask

  task automatic test_standard();
    int cyc, rhi, errs;
    logic [31:0] d;
    model_ks(STD_KEY);
    load_key(STD_KEY);
    wait_done(cyc, rhi);
    n_run++;
    if (cyc != 32) begin n_fail++; $display("FAIL std done latency: got %0d want 32", cyc); end
    n_run++;
    if (rhi != 0) begin n_fail++; $display("FAIL std key_ready during run: got %0d high cycles want 0", rhi); end
    n_run++;
    if (keys_valid !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL std status at done: got kv=%b kr=%b want 1 1", keys_valid, key_ready);
    end
    read_word(5'd0, 1'b0, d);
    n_run++;
    if (d !== 32'hF12186F9) begin n_fail++; $display("FAIL std rk0: got %h want F12186F9", d); end
    read_word(5'd1, 1'b0, d);
    n_run++;
    if (d !== 32'h41662B61) begin n_fail++; $display("FAIL std rk1: got %h want 41662B61", d); end
    read_word(5'd31, 1'b0, d);
    n_run++;
    if (d !== 32'h9124A012) begin n_fail++; $display("FAIL std rk31: got %h want 9124A012", d); end
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), 1'b0, d);
      if (d !== ref_rk[i]) errs++;
    end
    n_run++;
    if (errs != 0) begin n_fail++; $display("FAIL std full schedule: got %0d wrong words want 0", errs); end
  endtask

  task automatic test_decrypt();
    logic [31:0] d;
    read_word(5'd0, 1'b1, d);
    n_run++;
    if (d !== 32'h9124A012) begin n_fail++; $display("FAIL decrypt addr0: got %h want 9124A012", d); end
    read_word(5'd31, 1'b1, d);
    n_run++;
    if (d !== 32'hF12186F9) begin n_fail++; $display("FAIL decrypt addr31: got %h want F12186F9", d); end
    read_word(5'd30, 1'b1, d);
    n_run++;
    if (d !== 32'h41662B61) begin n_fail++; $display("FAIL decrypt addr30: got %h want 41662B61", d); end
  endtask

  task automatic test_busy();
    int first, pulses, errs;
    logic [31:0] d;
    model_ks(STD_KEY);
    load_key(STD_KEY);
    first = 0;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 9) begin
        n_run++;
        if (key_ready !== 1'b0) begin n_fail++; $display("FAIL busy key_ready: got %b want 0", key_ready); end
        key_in    = ALT_KEY;
        key_valid = 1'b1;
      end
      if (c == 10) key_valid = 1'b0;
    end
    n_run++;
    if (pulses != 1 || first != 32) begin
      n_fail++; $display("FAIL busy done pulses: got %0d (first at %0d) want 1 at 32", pulses, first);
    end
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), 1'b0, d);
      if (d !== ref_rk[i]) errs++;
    end
    n_run++;
    if (errs != 0) begin n_fail++; $display("FAIL busy schedule: got %0d wrong words want 0", errs); end
  endtask

  task automatic test_reload();
    int cyc, rhi, same, errs;
    logic [31:0] d;
    for (int i = 0; i < 32; i++) prev_rk[i] = ref_rk[i];
    model_ks(128'h0);
    n_run++;
    if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL reload kv before load: got %b want 1", keys_valid); end
    load_key(128'h0);
    n_run++;
    if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reload kv after load: got %b want 0", keys_valid); end
    wait_done(cyc, rhi);
    n_run++;
    if (cyc != 32 || keys_valid !== 1'b1) begin
      n_fail++; $display("FAIL reload completion: got done at %0d kv=%b want 32 1", cyc, keys_valid);
    end
    same = 0;
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), 1'b0, d);
      if (d === prev_rk[i]) same++;
      if (d !== ref_rk[i]) errs++;
      if (i == 0) begin
        n_run++;
        if (d !== ref_rk[0]) begin n_fail++; $display("FAIL reload rk0: got %h want %h", d, ref_rk[0]); end
      end
    end
    n_run++;
    if (same != 0) begin n_fail++; $display("FAIL reload overwrite: got %0d unchanged words want 0", same); end
    n_run++;
    if (errs != 0) begin n_fail++; $display("FAIL reload schedule: got %0d wrong words want 0", errs); end
  endtask

  task automatic test_reset_mid();
    int cyc, rhi, nz;
    logic [31:0] d;
    load_key(STD_KEY);
    repeat (15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_run++;
    if (key_ready !== 1'b1 || keys_valid !== 1'b0 || done !== 1'b0 || rk_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid reset outputs: got kr=%b kv=%b done=%b rk=%h want 1 0 0 00000000",
               key_ready, keys_valid, done, rk_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), i[0], d);
      if (d !== 32'h0) nz++;
    end
    n_run++;
    if (nz != 0) begin n_fail++; $display("FAIL mid reset buffer: got %0d nonzero words want 0", nz); end
    load_key(STD_KEY);
    wait_done(cyc, rhi);
    n_run++;
    if (cyc != 32) begin n_fail++; $display("FAIL mid reset rerun latency: got %0d want 32", cyc); end
    read_word(5'd0, 1'b0, d);
    n_run++;
    if (d !== 32'hF12186F9) begin n_fail++; $display("FAIL mid reset rerun rk0: got %h want F12186F9", d); end
    read_word(5'd0, 1'b1, d);
    n_run++;
    if (d !== 32'h9124A012) begin n_fail++; $display("FAIL mid reset rerun rk31: got %h want 9124A012", d); end
  endtask

  // Loads land at E0+33; round key i is read at E0+i+2, alternating decrypt so
  // both address mappings reach every key.
  task automatic test_back_to_back();
    logic [127:0] cur, nxt;
    logic [4:0]   idx;
    logic [31:0]  d;
    cur = rand_key();
    key_in    = cur;
    key_valid = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 200; n++) begin
      key_valid = 1'b0;
      model_ks(cur);
      nxt = rand_key();
      for (int c = 1; c <= 33; c++) begin
        @(posedge clk); #1;
        if (c >= 2) begin
          n_run++;
          if (rk_out !== ref_rk[c-2]) begin
            n_fail++; $display("FAIL b2b key %0d rk%0d: got %h want %h", n, c - 2, rk_out, ref_rk[c-2]);
          end
        end
        if (c == 32) begin
          n_run++;
          if (done !== 1'b1 || key_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b key %0d done/ready: got %b %b want 1 1", n, done, key_ready);
          end
        end
        if (c <= 32) begin
          idx     = 5'(c - 1);
          decrypt = idx[0];
          rk_addr = idx[0] ? (5'd31 - idx) : idx;
        end
        if (c == 32 && n < 199) begin
          key_in    = nxt;
          key_valid = 1'b1;
        end
      end
      cur = nxt;
    end
    for (int i = 0; i < 32; i++) begin
      read_word(5'(i), 1'b0, d);
      n_run++;
      if (d !== ref_rk[i]) begin n_fail++; $display("FAIL final fwd rk%0d: got %h want %h", i, d, ref_rk[i]); end
      read_word(5'(i), 1'b1, d);
      n_run++;
      if (d !== ref_rk[31-i]) begin
        n_fail++; $display("FAIL final dec addr%0d: got %h want %h", i, d, ref_rk[31-i]);
      end
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_addr   = '0;
    decrypt   = 1'b0;
    #3;
    test_reset();
    #9;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_standard();
    test_decrypt();
    test_busy();
    test_reload();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
